// File: rtl/adc_channel_scheduler_if.sv
// adc_channel_scheduler_if
// Handshake between the channel scheduler and the MCP3202 SPI ADC master core.
//   adc_start : one-cycle conversion start       (scheduler -> core)
//   adc_sgl   : single-ended / differential bit  (scheduler -> core)
//   adc_odd   : channel select                   (scheduler -> core)
//   adc_busy  : conversion in progress           (core -> scheduler)
//   adc_done  : one-cycle pulse, adc_data valid  (core -> scheduler)
//   adc_data  : 12-bit conversion result         (core -> scheduler)
// master = scheduler side, slave = ADC core side.
interface adc_channel_scheduler_if;
  logic        adc_start;
  logic        adc_sgl;
  logic        adc_odd;
  logic        adc_busy;
  logic        adc_done;
  logic [11:0] adc_data;

  modport master (
    output adc_start, adc_sgl, adc_odd,
    input  adc_busy, adc_done, adc_data
  );

  modport slave (
    input  adc_start, adc_sgl, adc_odd,
    output adc_busy, adc_done, adc_data
  );
endinterface

// File: rtl/adc_channel_scheduler.sv
// adc_channel_scheduler
// Sequences an MCP3202 SPI ADC master core on a fixed sample-slot grid.
//   mode=0 : free-running stereo, alternating ch0/ch1, left/right pairs out.
//   mode=1 : on-demand, req0 (ch0) / req1 (ch1) shared with round-robin.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   enable, mode          : run control and operating mode
//   req0/req1, ack0/ack1  : on-demand requesters (level req, pulse ack)
//   adc                   : ADC core handshake (adc_channel_scheduler_if.master)
//   result, result_ch     : last accepted result and its channel
//   left_data, right_data : free-run samples, pair_valid pulses on a new pair
//   overrun, err_timeout  : sticky status flags
// Optional feature macro: ADC_TIMEOUT_EN (WAIT-state timeout; otherwise
// WAIT waits indefinitely and err_timeout is tied to 0).
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | waiting for a slot tick with a candidate
// S_ISSUE | adc_start high for one cycle
// S_WAIT  | waiting for adc_done (or timeout when enabled)
module adc_channel_scheduler #(
  parameter int PERIOD_COUNT   = 3061,
  parameter bit SGL            = 1'b1,
  parameter int TIMEOUT_CYCLES = 3061
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           mode,
  input  logic                           req0,
  input  logic                           req1,
  output logic                           ack0,
  output logic                           ack1,
  adc_channel_scheduler_if.master        adc,
  output logic [11:0]                    result,
  output logic                           result_ch,
  output logic [11:0]                    left_data,
  output logic [11:0]                    right_data,
  output logic                           pair_valid,
  output logic                           overrun,
  output logic                           err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [11:0] SLOT_LAST = 12'(PERIOD_COUNT - 1);

  state_t      state;
  logic [11:0] slot_cnt;
  logic        slot_tick;
  logic        rr_last;     // last granted requester; 1 after reset so req0 wins first
  logic        fr_ch;       // next free-run channel
  logic        pair_flag;   // ch0 captured, waiting for ch1 to complete the pair
  logic        cur_mode;
  logic        cur_ch;
  logic        discard;     // enable dropped during this conversion
  logic        cand_valid;
  logic        cand_ch;

  assign slot_tick = enable && (slot_cnt == 12'd0);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      slot_cnt <= 12'd0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= 12'd0;
    end else begin
      slot_cnt <= slot_cnt + 12'd1;
    end
  end

  // Round-robin looks first at the requester after the last-granted one.
  always_comb begin
    cand_valid = 1'b0;
    cand_ch    = 1'b0;
    if (!mode) begin
      cand_valid = 1'b1;
      cand_ch    = fr_ch;
    end else if (rr_last) begin
      if (req0) begin
        cand_valid = 1'b1;
        cand_ch    = 1'b0;
      end else if (req1) begin
        cand_valid = 1'b1;
        cand_ch    = 1'b1;
      end
    end else begin
      if (req1) begin
        cand_valid = 1'b1;
        cand_ch    = 1'b1;
      end else if (req0) begin
        cand_valid = 1'b1;
        cand_ch    = 1'b0;
      end
    end
  end

`ifdef ADC_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      rr_last       <= 1'b1;
      fr_ch         <= 1'b0;
      pair_flag     <= 1'b0;
      cur_mode      <= 1'b0;
      cur_ch        <= 1'b0;
      discard       <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      adc.adc_start <= 1'b0;
      adc.adc_sgl   <= 1'b0;
      adc.adc_odd   <= 1'b0;
      result        <= 12'd0;
      result_ch     <= 1'b0;
      left_data     <= 12'd0;
      right_data    <= 12'd0;
      pair_valid    <= 1'b0;
      overrun       <= 1'b0;
`ifdef ADC_TIMEOUT_EN
      wait_cnt      <= '0;
      err_timeout   <= 1'b0;
`endif
    end else begin
      adc.adc_start <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      pair_valid    <= 1'b0;

      if (slot_tick && (state != S_IDLE || adc.adc_busy)) begin
        overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (slot_tick && cand_valid && !adc.adc_busy) begin
            cur_mode      <= mode;
            cur_ch        <= cand_ch;
            discard       <= 1'b0;
            adc.adc_start <= 1'b1;
            adc.adc_odd   <= cand_ch;
            adc.adc_sgl   <= SGL;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef ADC_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (adc.adc_done) begin
            state <= S_IDLE;
            if (!discard && enable) begin
              result    <= adc.adc_data;
              result_ch <= cur_ch;
              if (cur_mode) begin
                ack0    <= !cur_ch;
                ack1    <= cur_ch;
                rr_last <= cur_ch;
              end else if (!cur_ch) begin
                left_data <= adc.adc_data;
                pair_flag <= 1'b1;
                fr_ch     <= 1'b1;
              end else begin
                right_data <= adc.adc_data;
                fr_ch      <= 1'b0;
                pair_valid <= pair_flag;
                pair_flag  <= 1'b0;
              end
            end
          end
`ifdef ADC_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            state       <= S_IDLE;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase

      // Disabling restarts the stereo sequence on ch0 and poisons any
      // conversion still in flight; slot_tick is already gated by enable.
      if (!enable) begin
        overrun   <= 1'b0;
        fr_ch     <= 1'b0;
        pair_flag <= 1'b0;
        discard   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
module tb_adc_channel_scheduler;
  localparam int PERIOD = 100;

  logic        clk = 1'b0;
  logic        reset, enable, mode, req0, req1;
  logic        ack0, ack1;
  logic [11:0] result, left_data, right_data;
  logic        result_ch, pair_valid, overrun, err_timeout;

  adc_channel_scheduler_if adc ();

  adc_channel_scheduler #(
    .PERIOD_COUNT  (PERIOD),
    .SGL           (1'b1),
    .TIMEOUT_CYCLES(60)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .req0       (req0),
    .req1       (req1),
    .ack0       (ack0),
    .ack1       (ack1),
    .adc        (adc),
    .result     (result),
    .result_ch  (result_ch),
    .left_data  (left_data),
    .right_data (right_data),
    .pair_valid (pair_valid),
    .overrun    (overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ADC core model: done after done_delay cycles, busy meanwhile.
  int          done_delay = 40;
  bit          never_done = 1'b0;
  logic [11:0] data_q[$];
  int          m_cnt = 0;
  bit          m_act = 1'b0;

  always @(posedge clk) begin
    adc.adc_done <= 1'b0;
    if (reset) begin
      m_act        <= 1'b0;
      adc.adc_busy <= 1'b0;
      adc.adc_data <= 12'h000;
    end else if (m_act) begin
      if (m_cnt <= 1) begin
        adc.adc_done <= 1'b1;
        if (data_q.size() > 0) adc.adc_data <= data_q.pop_front();
        else adc.adc_data <= 12'h000;
        m_act        <= 1'b0;
        adc.adc_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (adc.adc_start && !never_done) begin
      m_act        <= 1'b1;
      adc.adc_busy <= 1'b1;
      m_cnt        <= done_delay;
    end
  end

  // Monitor with an independent slot-timer model; samples on the falling edge.
  int   cyc = 0;
  int   mt = 0;
  int   last_tick = -10;
  int   n_start = 0, n_ack0 = 0, n_ack1 = 0, n_pair = 0;
  int   start_cyc[$];
  logic odd_q[$];
  logic grant_q[$];
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (adc.adc_start) begin
      chk("start_after_tick", cyc, last_tick + 1);
      chk("start_width", {31'd0, prev_start}, 0);
      chk("start_sgl", {31'd0, adc.adc_sgl}, 1);
      n_start++;
      start_cyc.push_back(cyc);
      odd_q.push_back(adc.adc_odd);
    end
    prev_start = adc.adc_start;
    if (ack0) begin
      n_ack0++;
      grant_q.push_back(1'b0);
      chk("ack0_result_ch", {31'd0, result_ch}, 0);
    end
    if (ack1) begin
      n_ack1++;
      grant_q.push_back(1'b1);
      chk("ack1_result_ch", {31'd0, result_ch}, 1);
    end
    if (pair_valid) n_pair++;
    if (!reset && enable && mt == 0) last_tick = cyc;
    if (reset || !enable) mt = 0;
    else mt = (mt == PERIOD - 1) ? 0 : mt + 1;
  end

  task automatic clear_log();
    n_start = 0; n_ack0 = 0; n_ack1 = 0; n_pair = 0;
    start_cyc.delete(); odd_q.delete(); grant_q.delete();
  endtask

  function automatic int get_count(input int which);
    case (which)
      0:       return n_start;
      1:       return n_ack0 + n_ack1;
      default: return n_pair;
    endcase
  endfunction

  task automatic wait_count(input int which, input int target, input int budget, input string tag);
    int k = 0;
    while (get_count(which) < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(tag, {31'd0, get_count(which) >= target}, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_left", {20'd0, left_data}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {23'd0, ack0, ack1, adc.adc_start, adc.adc_sgl, adc.adc_odd,
                     result_ch, pair_valid, overrun, err_timeout}, 0);
    chk("rst_result", {20'd0, result}, 0);
    chk("rst_left_right", {8'd0, left_data, right_data}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (200) @(posedge clk);
    chk("disabled_no_start", n_start, 0);

    // Free-run stereo pair
    clear_log();
    data_q = '{12'h123, 12'hABC};
    #1 mode = 1'b0; enable = 1'b1;
    wait_count(2, 1, 300, "fr_pair_seen");
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    chk("fr_starts", n_start, 2);
    chk("fr_odd", {30'd0, odd_q[0], odd_q[1]}, 32'b01);
    chk("fr_gap", start_cyc[1] - start_cyc[0], PERIOD);
    chk("fr_left", {20'd0, left_data}, 32'h123);
    chk("fr_right", {20'd0, right_data}, 32'hABC);
    chk("fr_pairs", n_pair, 1);
    chk("fr_result", {19'd0, result_ch, result}, 32'h1ABC);

    // On-demand round-robin with both requests held
    do_reset();
    clear_log();
    data_q = '{12'h111, 12'h222, 12'h333, 12'h444};
    #1 mode = 1'b1; req0 = 1'b1; req1 = 1'b1; enable = 1'b1;
    wait_count(1, 4, 600, "od_acks_seen");
    #1 enable = 1'b0; req0 = 1'b0; req1 = 1'b0;
    chk("od_grants", {28'd0, grant_q[0], grant_q[1], grant_q[2], grant_q[3]}, 32'b0101);
    chk("od_odd", {28'd0, odd_q[0], odd_q[1], odd_q[2], odd_q[3]}, 32'b0101);
    chk("od_ack0", n_ack0, 2);
    chk("od_ack1", n_ack1, 2);
    chk("od_result", {19'd0, result_ch, result}, 32'h1444);

    // No request, then a request dropped before its slot
    repeat (3) @(posedge clk);
    clear_log();
    #1 enable = 1'b1;
    repeat (250) @(posedge clk);
    chk("od_noreq", n_start, 0);
    #1 req1 = 1'b1;
    repeat (20) @(posedge clk);
    #1 req1 = 1'b0;
    repeat (80) @(posedge clk);
    chk("od_dropped_req", n_start + n_ack1, 0);
    data_q = '{12'h777};
    #1 req0 = 1'b1;
    wait_count(1, 1, 200, "od_single_ack");
    #1 req0 = 1'b0;
    chk("od_single", {19'd0, result_ch, result}, 32'h0777);
    chk("od_single_acks", {n_ack0[15:0], n_ack1[15:0]}, 32'h0001_0000);

    // Overrun: conversion longer than a slot
    do_reset();
    clear_log();
    done_delay = 150;
    data_q = '{12'h321};
    #1 mode = 1'b0; enable = 1'b1;
    wait_count(0, 2, 300, "ovr_second_start");
    chk("ovr_flag", {31'd0, overrun}, 1);
    chk("ovr_gap", start_cyc[1] - start_cyc[0], 2 * PERIOD);
    chk("ovr_odd", {31'd0, odd_q[1]}, 1);
    chk("ovr_left", {20'd0, left_data}, 32'h321);
    // Reset while a conversion is in flight
    #1 reset = 1'b1; enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midop_reset", {30'd0, adc.adc_start, overrun}, 0);
    chk("midop_reset_left", {20'd0, left_data}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    done_delay = 40;

    // Enable dropped during a ch1 conversion
    do_reset();
    clear_log();
    data_q = '{12'h5A5, 12'hBAD, 12'h0F0};
    #1 mode = 1'b0; enable = 1'b1;
    wait_count(0, 2, 300, "en_second_start");
    repeat (11) @(posedge clk);
    #1 enable = 1'b0;
    repeat (60) @(posedge clk);
    chk("en_left", {20'd0, left_data}, 32'h5A5);
    chk("en_right_discard", {20'd0, right_data}, 0);
    chk("en_result", {19'd0, result_ch, result}, 32'h05A5);
    chk("en_no_pair", n_pair, 0);
    #1 enable = 1'b1;
    wait_count(0, 3, 50, "en_restart");
    chk("en_restart_odd", {31'd0, odd_q[2]}, 0);
    repeat (60) @(posedge clk);
    chk("en_restart_left", {20'd0, left_data}, 32'h0F0);
    #1 enable = 1'b0;

`ifdef ADC_TIMEOUT_EN
    // Timeout: ADC never answers
    do_reset();
    clear_log();
    never_done = 1'b1;
    #1 mode = 1'b1; req0 = 1'b1; enable = 1'b1;
    wait_count(0, 1, 50, "to_first_start");
    repeat (60) @(negedge clk);
    chk("to_before", {31'd0, err_timeout}, 0);
    @(negedge clk);
    chk("to_flag", {31'd0, err_timeout}, 1);
    wait_count(0, 2, 150, "to_reissue");
    chk("to_gap", start_cyc[1] - start_cyc[0], PERIOD);
    chk("to_reissue_odd", {31'd0, odd_q[1]}, 0);
    chk("to_no_ack", n_ack0 + n_ack1, 0);
    chk("to_status", {30'd0, err_timeout, overrun}, 32'b10);
    #1 enable = 1'b0; req0 = 1'b0;
    never_done = 1'b0;
`endif

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/adc_channel_scheduler.md
Name: adc_channel_scheduler

Overview:
Sequences a runtime-configurable MCP3202 SPI ADC master core, which has per-conversion start, SGL and ODD inputs. Operating modes:
- Free-running stereo: alternates ch0/ch1 on a fixed sample-slot grid and presents left/right pairs to the audio path.
- On-demand: shares the ADC between two requesters with round-robin arbitration.
Sits between the SPI ADC master and the mixer/host-register logic; the only clock is the 135 MHz system clock.

Parameters:
PERIOD_COUNT, 3061, system clocks per conversion slot (135 MHz / 3061 ≈ 44.1 kHz); legal range 2..4096.
SGL, 1, value driven on adc_sgl (1 = single-ended).
TIMEOUT_CYCLES, 3061, WAIT-state limit in clocks; used only with ADC_TIMEOUT_EN.

Ports:
clk  in  1  system clock, 135 MHz
reset  in  1  synchronous, active-high
enable  in  1  1 = scheduler running
mode  in  1  0 = free-run stereo, 1 = on-demand
req0  in  1  requester 0 wants a ch0 conversion (level, held until ack0)
req1  in  1  requester 1 wants a ch1 conversion (level, held until ack1)
ack0  out  1  one-cycle pulse: result valid for requester 0
ack1  out  1  one-cycle pulse: result valid for requester 1
adc_start  out  1  one-cycle conversion start to ADC core
adc_sgl  out  1  mode bit to ADC core
adc_odd  out  1  channel select to ADC core
adc_busy  in  1  ADC core conversion in progress
adc_done  in  1  one-cycle pulse: adc_data valid
adc_data  in  12  conversion result
result  out  12  last accepted result (any mode)
result_ch  out  1  channel of result
left_data  out  12  free-run ch0 sample
right_data  out  12  free-run ch1 sample
pair_valid  out  1  one-cycle pulse: new left/right pair
overrun  out  1  sticky: a slot tick was missed
err_timeout  out  1  sticky: conversion timed out

Behaviour:
Reset:
- All outputs are 0 and state is IDLE.
- Slot timer = 0, RR pointer = 1 (requester 0 wins first), free-run channel = 0, pair flag = 0.

Slot timer:
- 12-bit counter, counts 0..PERIOD_COUNT-1 and wraps while enable=1.
- slot_tick is high when the counter = 0 and enable=1.
- enable=0 holds the timer at 0.

States:
- IDLE: on slot_tick with enable=1, a candidate present and adc_busy=0, latch mode and the channel, then go to ISSUE. Otherwise stay.
  - Free-run candidate: always the free-run channel.
  - On-demand candidate: round-robin over req0/req1, starting after the last-granted requester. No request present means no start.
- ISSUE: adc_start=1 for exactly one cycle; adc_odd = channel; adc_sgl = SGL. Go to WAIT. adc_start therefore rises 1 cycle after slot_tick.
- WAIT: on adc_done, register adc_data into result, set result_ch, go to IDLE. Outputs update on the cycle after adc_done.
  - On-demand completion: pulse ack0 or ack1 in that same cycle and update the RR pointer.
  - Free-run ch0 completion: update left_data, set pair flag, toggle the channel.
  - Free-run ch1 completion: update right_data, toggle the channel, and pulse pair_valid only if the pair flag is set; then clear the pair flag.

Boundary conditions:
- A slot_tick outside IDLE, or with adc_busy=1, is skipped and overrun is set. overrun clears only on reset or enable=0.
- Requester drops req before grant: not served, no ack.
- Requester holds req after ack: served again at a later slot, subject to round-robin.
- mode is sampled only in IDLE; a change mid-conversion takes effect next slot.
- enable=0 in ISSUE/WAIT: adc_start is still completed. The block then waits for adc_done, discards the data (no result, ack or valid update) and returns to IDLE.
- enable=0 at any time resets the free-run channel to 0 and clears the pair flag.
- adc_done seen in IDLE/ISSUE: ignored.
- Reset mid-operation: immediate return to reset values; adc_start deasserts.

Optional Feature:
ADC_TIMEOUT_EN:
- Defined: a WAIT-state counter starts at 0 on entry and increments each cycle. When it reaches TIMEOUT_CYCLES without adc_done, go to IDLE, set err_timeout sticky (cleared by reset only), issue no ack/valid, leave requests pending and leave the free-run channel unchanged.
- Undefined: WAIT waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Bench setup: PERIOD_COUNT=100; ADC model asserts adc_done 40 cycles after adc_start.
- Reset: hold reset 3 cycles -> all outputs 0, no adc_start for 200 cycles with enable=0.
- Free-run: enable=1, mode=0, model returns 0x123 then 0xABC -> adc_start 1 cycle after each tick with adc_odd 0, then 1; left_data=0x123, right_data=0xABC; exactly one pair_valid pulse.
- On-demand round-robin: mode=1, req0=req1=1 held -> grants alternate 0,1,0,1 on successive slots; ack0 and ack1 each pulse once per grant; result_ch matches.
- Overrun: model done delay 150 -> the tick during WAIT is skipped, overrun=1, next conversion starts at the following tick.
- Enable drop: deassert enable 10 cycles into WAIT -> done is discarded, no ack/pair_valid; after re-enable the first free-run conversion has adc_odd=0.
- Timeout (ADC_TIMEOUT_EN, TIMEOUT_CYCLES=60, model never returns done) -> err_timeout=1 at 60 cycles into WAIT, state IDLE, pending req0 reissued at the next tick.
